// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed N-digit hex 7-segment driver. Scans one digit per refresh slot
// and drives shared segment lines {g,f,e,d,c,b,a} plus one-hot digit enables.
// New value/blank_mask pairs are double-buffered and only take effect at the frame
// boundary (scan wrapping from the last digit back to digit 0), so a frame never tears.
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, leading zero digits
// (above digit 0) are automatically darkened in addition to the blank mask.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_i,
   input  logic [4*NUM_DIGITS-1:0]   value_i,
   input  logic [NUM_DIGITS-1:0]     blank_mask_i,
   output logic [6:0]                seg_o,
   output logic [NUM_DIGITS-1:0]     an_o,
   output logic                      frame_done_o
);

   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRESC_W = $clog2(REFRESH_DIV);

   localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [PRESC_W-1:0]    PRESC_PRE  = PRESC_W'(REFRESH_DIV - 2);
   localparam logic [PRESC_W-1:0]    PRESC_ONE  = PRESC_W'(1);
   localparam logic [PRESC_W-1:0]    PRESC_ZERO = PRESC_W'(0);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
   localparam logic [IDX_W-1:0]      IDX_ZERO   = IDX_W'(0);
   localparam logic [6:0]            SEG_DARK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = (DIG_ACTIVE_LOW != 0) ?
                                                  {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   // Active-high hex-to-segment encoding, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h58;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         4'hF:    s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [PRESC_W-1:0]      presc_q,     presc_d;
   logic [IDX_W-1:0]        idx_q,       idx_d;
   logic [4*NUM_DIGITS-1:0] disp_val_q,  disp_val_d;
   logic [NUM_DIGITS-1:0]   disp_mask_q, disp_mask_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q,  pend_val_d;
   logic [NUM_DIGITS-1:0]   pend_mask_q, pend_mask_d;
   logic                    pend_vld_q,  pend_vld_d;
   logic                    frame_done_q, frame_done_d;
   logic [6:0]              seg_q,       seg_d;
   logic [NUM_DIGITS-1:0]   an_q,        an_d;

   logic                    tick_s;
   logic                    last_s;
   logic                    boundary_s;
   logic [NUM_DIGITS-1:0]   lz_s;
   logic [3:0]              nib_s;
   logic                    blank_s;
   logic [6:0]              lit_s;
   logic                    zero_run_s;

   // Leading-zero mask: a digit is auto-blanked when it and every digit above it are zero.
   always_comb begin
      lz_s       = {NUM_DIGITS{1'b0}};
      zero_run_s = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (disp_val_q[4*k +: 4] != 4'h0) begin
            zero_run_s = 1'b0;
         end else begin
            zero_run_s = zero_run_s;
         end
         lz_s[k] = zero_run_s;
      end
`else
      zero_run_s = 1'b0;
`endif
   end

   // Next-state: prescaler, scan index, double buffer, and the registered display outputs.
   always_comb begin
      tick_s      = (presc_q == PRESC_LAST);
      last_s      = (idx_q == IDX_LAST);
      boundary_s  = tick_s && last_s;

      presc_d     = presc_q;
      idx_d       = idx_q;
      disp_val_d  = disp_val_q;
      disp_mask_d = disp_mask_q;
      pend_val_d  = pend_val_q;
      pend_mask_d = pend_mask_q;
      pend_vld_d  = pend_vld_q;

      if (tick_s) begin
         presc_d = PRESC_ZERO;
         if (last_s) begin
            idx_d = IDX_ZERO;
         end else begin
            idx_d = idx_q + IDX_ONE;
         end
      end else begin
         presc_d = presc_q + PRESC_ONE;
      end

      // A load coinciding with the boundary bypasses the buffer and wins over it.
      if (boundary_s) begin
         if (load_i) begin
            disp_val_d  = value_i;
            disp_mask_d = blank_mask_i;
            pend_vld_d  = 1'b0;
         end else if (pend_vld_q) begin
            disp_val_d  = pend_val_q;
            disp_mask_d = pend_mask_q;
            pend_vld_d  = 1'b0;
         end else begin
            pend_vld_d  = pend_vld_q;
         end
      end else if (load_i) begin
         pend_val_d  = value_i;
         pend_mask_d = blank_mask_i;
         pend_vld_d  = 1'b1;
      end else begin
         pend_vld_d  = pend_vld_q;
      end

      // Pulse lands in the cycle whose clock edge performs the wrap, so a load
      // seen together with frame_done is applied on that same edge.
      frame_done_d = (presc_q == PRESC_PRE) && last_s;

      nib_s   = 4'h0;
      blank_s = 1'b0;
      an_d    = AN_OFF;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_s    = disp_val_q[4*k +: 4];
            blank_s  = disp_mask_q[k] | lz_s[k];
            an_d[k]  = ~AN_OFF[k];
         end else begin
            an_d[k]  = AN_OFF[k];
         end
      end

      if (blank_s) begin
         lit_s = 7'h00;
      end else begin
         lit_s = hex_to_seg(nib_s);
      end

      if (SEG_ACTIVE_LOW != 0) begin
         seg_d = ~lit_s;
      end else begin
         seg_d = lit_s;
      end
   end

   // State and output registers; reset restarts the scan at digit 0 and drops pending data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= PRESC_ZERO;
         idx_q        <= IDX_ZERO;
         disp_val_q   <= {(4*NUM_DIGITS){1'b0}};
         disp_mask_q  <= {NUM_DIGITS{1'b0}};
         pend_val_q   <= {(4*NUM_DIGITS){1'b0}};
         pend_mask_q  <= {NUM_DIGITS{1'b0}};
         pend_vld_q   <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_DARK;
         an_q         <= AN_OFF;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         disp_val_q   <= disp_val_d;
         disp_mask_q  <= disp_mask_d;
         pend_val_q   <= pend_val_d;
         pend_mask_q  <= pend_mask_d;
         pend_vld_q   <= pend_vld_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
      end
   end

   assign seg_o        = seg_q;
   assign an_o         = an_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4 digits, 4 clk per slot.
// Two instances share stimulus: active-low polarities and active-high polarities.
module tb_seven_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  bmask;
   logic [6:0]  seg_lo, seg_hi;
   logic [3:0]  an_lo,  an_hi;
   logic        fd_lo,  fd_hi;

   int tests = 0;
   int fails = 0;

   seven_seg_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) u_dut_lo (
      .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .blank_mask_i(bmask),
      .seg_o(seg_lo), .an_o(an_lo), .frame_done_o(fd_lo)
   );

   seven_seg_scan_driver #(
      .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) u_dut_hi (
      .clk(clk), .rst_n(rst_n), .load_i(load), .value_i(value), .blank_mask_i(bmask),
      .seg_o(seg_hi), .an_o(an_hi), .frame_done_o(fd_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] enc(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h58;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Expected lit segments (active-high) for digit d of a displayed value/mask.
   function automatic logic [6:0] lit_of(input logic [15:0] ev, input logic [3:0] em, input int d);
      logic [15:0] sh;
      logic        blank;
      sh    = ev >> (4 * d);
      blank = em[d];
`ifdef LEADING_ZERO_BLANK_EN
      if (d != 0 && sh == 16'h0000) blank = 1'b1;
`endif
      return blank ? 7'h00 : enc(sh[3:0]);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_seg_lo", {9'h000, seg_lo}, 16'h007F);
      chk("rst_an_lo",  {12'h000, an_lo}, 16'h000F);
      chk("rst_fd_lo",  {15'h0000, fd_lo}, 16'h0000);
      chk("rst_seg_hi", {9'h000, seg_hi}, 16'h0000);
      chk("rst_an_hi",  {12'h000, an_hi}, 16'h0000);
      chk("rst_fd_hi",  {15'h0000, fd_hi}, 16'h0000);
   endtask

   // Checks one full 16-cycle frame starting right after a boundary edge.
   // A load scheduled at sample i is applied on the following clock edge.
   task automatic check_frame(input logic [15:0] ev, input logic [3:0] em,
                              input int la, input logic [15:0] va, input logic [3:0] ma,
                              input int lb, input logic [15:0] vb, input logic [3:0] mb);
      int         d;
      logic [6:0] lit;
      logic [3:0] an_exp;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         load   = 1'b0;
         d      = (i - 1) / 4;
         lit    = lit_of(ev, em, d);
         an_exp = 4'b0001 << d;
         chk($sformatf("seg_lo %h s%0d", ev, i), {9'h000, seg_lo}, {9'h000, ~lit});
         chk($sformatf("an_lo %h s%0d", ev, i),  {12'h000, an_lo}, {12'h000, ~an_exp});
         chk($sformatf("fd_lo %h s%0d", ev, i),  {15'h0000, fd_lo}, {15'h0000, (i == 15)});
         chk($sformatf("seg_hi %h s%0d", ev, i), {9'h000, seg_hi}, {9'h000, lit});
         chk($sformatf("an_hi %h s%0d", ev, i),  {12'h000, an_hi}, {12'h000, an_exp});
         chk($sformatf("fd_hi %h s%0d", ev, i),  {15'h0000, fd_hi}, {15'h0000, (i == 15)});
         if (i == la) begin
            load = 1'b1; value = va; bmask = ma;
         end
         if (i == lb) begin
            load = 1'b1; value = vb; bmask = mb;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      value = 16'h0000;
      bmask = 4'h0;
      repeat (3) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;

      // Frame 0: reset contents; queue 1234 mid-frame.
      check_frame(16'h0000, 4'h0, 5, 16'h1234, 4'h0, -1, 16'h0000, 4'h0);
      // 1234 shown; ABCD then 00EF queued mid-frame (last one wins).
      check_frame(16'h1234, 4'h0, 3, 16'hABCD, 4'h0, 9, 16'h00EF, 4'h0);
      // 00EF shown; 5678 loaded together with frame_done.
      check_frame(16'h00EF, 4'h0, 15, 16'h5678, 4'h0, -1, 16'h0000, 4'h0);
      // 5678 shown; nothing stale is pending afterward; load 8888 with mask at boundary.
      check_frame(16'h5678, 4'h0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
      check_frame(16'h5678, 4'h0, 15, 16'h8888, 4'b1010, -1, 16'h0000, 4'h0);
      // Blanked digits 1,3 keep their enable; then 0070 for leading-zero handling.
      check_frame(16'h8888, 4'b1010, 15, 16'h0070, 4'h0, -1, 16'h0000, 4'h0);
      // 0070 shown; queue 9999 that the upcoming reset must discard.
      check_frame(16'h0070, 4'h0, 2, 16'h9999, 4'h0, -1, 16'h0000, 4'h0);

      // Reset mid-frame: outputs go dark immediately.
      repeat (5) @(negedge clk);
      load  = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset();
      @(negedge clk);
      chk_reset();
      rst_n = 1'b1;

      // Scan restarts at digit 0 with cleared contents; pending 9999 never appears.
      check_frame(16'h0000, 4'h0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);
      check_frame(16'h0000, 4'h0, -1, 16'h0000, 4'h0, -1, 16'h0000, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
